// File: rtl/mem_map_pkg.sv
// Memory-map constants shared by the responder, the LSB and the IF.
// IO window lives at 0x3xxxx; offsets are the low 16 address bits.
package mem_map_pkg;

   localparam logic [1:0]  IO_BASE_HI = 2'b11;
   localparam logic [15:0] OFF_TX     = 16'h0000;
   localparam logic [15:0] OFF_STAT   = 16'h0004;
   localparam logic [15:0] OFF_HALT   = 16'h0004;
   localparam logic [15:0] OFF_CNT    = 16'h0008;

   typedef struct packed {
      logic [31:0] a;
      logic        wr;
      logic [7:0]  wdata;
   } mem_req_t;

   function automatic logic is_io(input logic [31:0] a);
      return a[17:16] == IO_BASE_HI;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// TX byte FIFO with a registered head byte and a registered almost-full flag.
// Pushes into a full FIFO are dropped; the caller tracks overflow.
module byte_fifo #(
   parameter int FIFO_DEPTH = 8,
   parameter int FIFO_WIDTH = 3
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       en,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] head_data,
   output logic       empty,
   output logic       full,
   output logic       almost_full
);

   localparam int                  AF_I    = FIFO_DEPTH - 2;
   localparam int                  ONE_I   = 1;
   localparam logic [FIFO_WIDTH:0] DEPTH_C = FIFO_DEPTH[FIFO_WIDTH:0];
   localparam logic [FIFO_WIDTH:0] AF_LVL  = AF_I[FIFO_WIDTH:0];
   localparam logic [FIFO_WIDTH:0] CNT_ONE = ONE_I[FIFO_WIDTH:0];
   localparam logic [FIFO_WIDTH-1:0] PTR_ONE = ONE_I[FIFO_WIDTH-1:0];

   logic [7:0]            mem [FIFO_DEPTH];
   logic [FIFO_WIDTH-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
   logic [FIFO_WIDTH:0]   count, count_nxt;
   logic                  push_ok, pop_ok;
   logic [7:0]            head_nxt;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_C);
   assign push_ok = en && push && !full;
   assign pop_ok  = en && pop && !empty;

   always_comb begin
      count_nxt = count;
      if (push_ok && !pop_ok)
         count_nxt = count + CNT_ONE;
      else if (pop_ok && !push_ok)
         count_nxt = count - CNT_ONE;
      rd_ptr_nxt = pop_ok ? rd_ptr + PTR_ONE : rd_ptr;
      // The new head is the byte being pushed only when the FIFO drains to it this cycle.
      head_nxt = (push_ok && (wr_ptr == rd_ptr_nxt)) ? push_data : mem[rd_ptr_nxt];
   end

   always_ff @(posedge clk_in) begin
      if (push_ok)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         head_data   <= 8'h00;
         almost_full <= 1'b0;
      end else if (en) begin
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_ONE;
         rd_ptr      <= rd_ptr_nxt;
         count       <= count_nxt;
         almost_full <= (count_nxt >= AF_LVL);
         if (count_nxt != '0)
            head_data <= head_nxt;
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Byte-wide memory responder: RAM with registered reads plus an IO window at 0x3xxxx.
// Optional cycle counter at 0x30008..0x3000B when MEM_RESP_CYCLE_CNT_EN is defined.
module mem_responder
   import mem_map_pkg::*;
#(
   parameter int ADDR_WIDTH = 17,
   parameter int FIFO_DEPTH = 8,
   parameter int FIFO_WIDTH = 3
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_wdata,
   output logic [7:0]  mem_rdata,
   output logic        io_buffer_full,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        sim_done
);

   mem_req_t        req;
   logic            io;
   logic [15:0]     off;
   logic [ADDR_WIDTH-1:0] ram_a;
   logic [7:0]      ram [2**ADDR_WIDTH];
   logic [7:0]      io_rdata, cnt_byte;
   logic            tx_push, fifo_empty, fifo_full, overflow;
   logic            unused_addr;

   assign req.a      = mem_a;
   assign req.wr     = mem_wr;
   assign req.wdata  = mem_wdata;
   assign io         = is_io(req.a);
   assign off        = req.a[15:0];
   assign ram_a      = req.a[ADDR_WIDTH-1:0];
   assign unused_addr = ^req.a[31:18];

   assign tx_push  = rdy_in && req.wr && io && (off == OFF_TX);
   assign tx_valid = !fifo_empty;

   byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .FIFO_WIDTH(FIFO_WIDTH)) u_fifo (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .en          (rdy_in),
      .push        (tx_push),
      .push_data   (req.wdata),
      .pop         (tx_valid && tx_ready),
      .head_data   (tx_data),
      .empty       (fifo_empty),
      .full        (fifo_full),
      .almost_full (io_buffer_full)
   );

`ifdef MEM_RESP_CYCLE_CNT_EN
   logic [31:0] cyc_cnt;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
         cyc_cnt <= '0;
      else if (rdy_in && (cyc_cnt != '1))
         cyc_cnt <= cyc_cnt + 32'd1;
   end

   assign cnt_byte = cyc_cnt[{off[1:0], 3'b000} +: 8];
`else
   assign cnt_byte = 8'h00;
`endif

   always_comb begin
      io_rdata = 8'h00;
      if (off == OFF_STAT)
         io_rdata = {6'b0, overflow, fifo_full};
      else if (off[15:2] == OFF_CNT[15:2])
         io_rdata = cnt_byte;
   end

   always_ff @(posedge clk_in) begin
      if (rdy_in && req.wr && !io)
         ram[ram_a] <= req.wdata;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         mem_rdata <= 8'h00;
         sim_done  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         sim_done <= rdy_in && req.wr && io && (off == OFF_HALT);
         if (rdy_in && !req.wr)
            mem_rdata <= io ? io_rdata : ram[ram_a];
         if (tx_push && fifo_full)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM path, IO window, TX FIFO, HALT pulse, reset, counter.
module tb_mem_responder;

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic        rdy_in = 1'b0;
   logic [31:0] mem_a = '0;
   logic        mem_wr = 1'b0;
   logic [7:0]  mem_wdata = '0;
   logic [7:0]  mem_rdata;
   logic        io_buffer_full;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;
   logic        sim_done;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] popped [$];

   mem_responder dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
      .mem_a(mem_a), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .io_buffer_full(io_buffer_full), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .sim_done(sim_done)
   );

   always #5 clk_in = ~clk_in;

   // One clock: record a handshake that completes on this edge, then settle past it.
   task automatic step();
      if (rdy_in && tx_valid && tx_ready) popped.push_back(tx_data);
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [7:0] d);
      mem_a = a; mem_wr = 1'b1; mem_wdata = d;
      step();
   endtask

   task automatic do_read(input logic [31:0] a);
      mem_a = a; mem_wr = 1'b0;
      step();
   endtask

   task automatic apply_reset();
      rst_n_in = 1'b0; rdy_in = 1'b1; tx_ready = 1'b0; mem_wr = 1'b0; mem_a = '0;
      repeat (2) @(posedge clk_in);
      #1 rst_n_in = 1'b1;
   endtask

   task automatic test_reset();
      rst_n_in = 1'b0;
      #2;
      n_cmp++; if (mem_rdata !== 8'h00) begin n_err++; $display("FAIL rst_rdata got %h exp 00", mem_rdata); end
      n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid); end
      n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst_tx_data got %h exp 00", tx_data); end
      n_cmp++; if (io_buffer_full !== 1'b0) begin n_err++; $display("FAIL rst_buf_full got %b exp 0", io_buffer_full); end
      n_cmp++; if (sim_done !== 1'b0) begin n_err++; $display("FAIL rst_sim_done got %b exp 0", sim_done); end
      apply_reset();
   endtask

   task automatic test_ram_basic();
      do_write(32'h0000_0010, 8'hA5);
      do_read(32'h0000_0010);
      n_cmp++; if (mem_rdata !== 8'hA5) begin n_err++; $display("FAIL ram_rd got %h exp a5", mem_rdata); end
      do_read(32'h0000_0010);
      n_cmp++; if (mem_rdata !== 8'hA5) begin n_err++; $display("FAIL ram_reread got %h exp a5", mem_rdata); end
      do_write(32'h0000_0020, 8'h5A);
      n_cmp++; if (mem_rdata !== 8'hA5) begin n_err++; $display("FAIL wr_hold got %h exp a5", mem_rdata); end
      // Bits above the RAM index are ignored, so 0x40010 aliases 0x00010.
      do_write(32'h0004_0010, 8'h3C);
      do_read(32'h0000_0010);
      n_cmp++; if (mem_rdata !== 8'h3C) begin n_err++; $display("FAIL ram_alias got %h exp 3c", mem_rdata); end
      do_read(32'h0000_0020);
      n_cmp++; if (mem_rdata !== 8'h5A) begin n_err++; $display("FAIL ram_rd2 got %h exp 5a", mem_rdata); end
      rdy_in = 1'b0;
      do_read(32'h0000_0010);
      n_cmp++; if (mem_rdata !== 8'h5A) begin n_err++; $display("FAIL rdy_hold got %h exp 5a", mem_rdata); end
      do_write(32'h0000_0010, 8'hFF);
      rdy_in = 1'b1;
      do_read(32'h0000_0010);
      n_cmp++; if (mem_rdata !== 8'h3C) begin n_err++; $display("FAIL rdy_nowr got %h exp 3c", mem_rdata); end
   endtask

   task automatic test_stream();
      logic [7:0] exp_b [4];
      exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) do_write(32'(i), exp_b[i]);
      for (int i = 0; i < 4; i++) begin
         do_read(32'(i));
         n_cmp++;
         if (mem_rdata !== exp_b[i]) begin
            n_err++; $display("FAIL stream[%0d] got %h exp %h", i, mem_rdata, exp_b[i]);
         end
      end
   endtask

   task automatic test_fifo_fill();
      int guard;
      apply_reset();
      for (int i = 0; i < 5; i++) do_write(32'h0003_0000, 8'hB0 + 8'(i));
      n_cmp++; if (io_buffer_full !== 1'b0) begin n_err++; $display("FAIL af_at5 got %b exp 0", io_buffer_full); end
      n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'hB0) begin n_err++; $display("FAIL head_at5 got %b/%h exp 1/b0", tx_valid, tx_data); end
      do_write(32'h0003_0000, 8'hB5);
      n_cmp++; if (io_buffer_full !== 1'b1) begin n_err++; $display("FAIL af_at6 got %b exp 1", io_buffer_full); end
      for (int i = 6; i < 9; i++) do_write(32'h0003_0000, 8'hB0 + 8'(i));
      do_read(32'h0003_0004);
      n_cmp++; if (mem_rdata !== 8'h03) begin n_err++; $display("FAIL stat_full got %h exp 03", mem_rdata); end
      do_read(32'h0003_0000);
      n_cmp++; if (mem_rdata !== 8'h00) begin n_err++; $display("FAIL io_tx_rd got %h exp 00", mem_rdata); end
      popped.delete();
      mem_a = '0; tx_ready = 1'b1;
      guard = 0;
      while (tx_valid && guard < 20) begin step(); guard++; end
      tx_ready = 1'b0;
      n_cmp++; if (popped.size() !== 8) begin n_err++; $display("FAIL drain_cnt got %0d exp 8", popped.size()); end
      for (int i = 0; i < 8 && i < popped.size(); i++) begin
         n_cmp++;
         if (popped[i] !== 8'hB0 + 8'(i)) begin
            n_err++; $display("FAIL drain[%0d] got %h exp %h", i, popped[i], 8'hB0 + 8'(i));
         end
      end
      n_cmp++; if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0) begin n_err++; $display("FAIL drained got %b/%b exp 0/0", tx_valid, io_buffer_full); end
      do_read(32'h0003_0004);
      n_cmp++; if (mem_rdata !== 8'h02) begin n_err++; $display("FAIL stat_sticky got %h exp 02", mem_rdata); end
   endtask

   task automatic test_push_pop();
      int guard;
      logic [7:0] exp_b [4];
      exp_b = '{8'h10, 8'h11, 8'h12, 8'h13};
      apply_reset();
      for (int i = 0; i < 3; i++) do_write(32'h0003_0000, exp_b[i]);
      popped.delete();
      tx_ready = 1'b1;
      do_write(32'h0003_0000, exp_b[3]);
      n_cmp++; if (tx_data !== 8'h11 || io_buffer_full !== 1'b0) begin n_err++; $display("FAIL pushpop_head got %h/%b exp 11/0", tx_data, io_buffer_full); end
      mem_wr = 1'b0; mem_a = '0;
      guard = 0;
      while (tx_valid && guard < 20) begin step(); guard++; end
      tx_ready = 1'b0;
      n_cmp++; if (popped.size() !== 4) begin n_err++; $display("FAIL pushpop_cnt got %0d exp 4", popped.size()); end
      for (int i = 0; i < 4 && i < popped.size(); i++) begin
         n_cmp++;
         if (popped[i] !== exp_b[i]) begin
            n_err++; $display("FAIL pushpop[%0d] got %h exp %h", i, popped[i], exp_b[i]);
         end
      end
   endtask

   task automatic test_halt();
      apply_reset();
      do_write(32'h0003_0004, 8'h00);
      n_cmp++; if (sim_done !== 1'b1) begin n_err++; $display("FAIL halt_pulse got %b exp 1", sim_done); end
      n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL halt_nopush got %b exp 0", tx_valid); end
      do_read(32'h0000_0000);
      n_cmp++; if (sim_done !== 1'b0) begin n_err++; $display("FAIL halt_1cyc got %b exp 0", sim_done); end
      rdy_in = 1'b0;
      do_write(32'h0003_0004, 8'h00);
      n_cmp++; if (sim_done !== 1'b0) begin n_err++; $display("FAIL halt_nordy got %b exp 0", sim_done); end
      rdy_in = 1'b1; mem_wr = 1'b0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int i = 0; i < 3; i++) do_write(32'h0003_0000, 8'hC0 + 8'(i));
      tx_ready = 1'b1;
      do_write(32'h0003_0004, 8'h00);
      n_cmp++; if (tx_valid !== 1'b1 || sim_done !== 1'b1 || tx_data !== 8'hC1) begin
         n_err++; $display("FAIL mid_pre got %b/%b/%h exp 1/1/c1", tx_valid, sim_done, tx_data);
      end
      mem_wr = 1'b0;
      #2 rst_n_in = 1'b0;
      #1;
      n_cmp++; if (tx_valid !== 1'b0 || sim_done !== 1'b0 || tx_data !== 8'h00) begin
         n_err++; $display("FAIL mid_rst got %b/%b/%h exp 0/0/00", tx_valid, sim_done, tx_data);
      end
      apply_reset();
   endtask

   task automatic test_counter();
      logic [7:0] exp_lo, exp_hi;
`ifdef MEM_RESP_CYCLE_CNT_EN
      exp_lo = 8'h2C; exp_hi = 8'h01;
`else
      exp_lo = 8'h00; exp_hi = 8'h00;
`endif
      apply_reset();
      repeat (300) step();
      do_read(32'h0003_0008);
      n_cmp++; if (mem_rdata !== exp_lo) begin n_err++; $display("FAIL cnt_b0 got %h exp %h", mem_rdata, exp_lo); end
      do_read(32'h0003_0009);
      n_cmp++; if (mem_rdata !== exp_hi) begin n_err++; $display("FAIL cnt_b1 got %h exp %h", mem_rdata, exp_hi); end
      do_read(32'h0003_000B);
      n_cmp++; if (mem_rdata !== 8'h00) begin n_err++; $display("FAIL cnt_b3 got %h exp 00", mem_rdata); end
   endtask

   initial begin
      test_reset();
      test_ram_basic();
      test_stream();
      test_fifo_fill();
      test_push_pop();
      test_halt();
      test_reset_mid();
      test_counter();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

endmodule
